// File: rtl/vseq_pkg.sv
// Shared types and sizing helpers for the vector memory sequencer.
package vseq_pkg;

   localparam int unsigned VEC_W = 256;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} vseq_state_e;

   function automatic int unsigned beats_of(input int unsigned beat_w);
      return VEC_W / beat_w;
   endfunction

   // Counter width that stays legal when only one beat exists.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vseq_watchdog.sv
// Per-beat wait counter; expire fires on the TIMEOUT-th consecutive not-ready ACCESS cycle.
module vseq_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic ready,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (!active || ready) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire = active && !ready && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits a 256-bit vector load/store into BEAT_W-wide memory beats, stalling the pipeline meanwhile.
// Optional per-beat watchdog enabled by defining VSEQ_TIMEOUT_EN.
module vector_mem_sequencer
   import vseq_pkg::*;
#(
   parameter int unsigned N       = 24,
   parameter int unsigned BEAT_W  = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vMemOpM,
   input  logic              vWriteM,
   input  logic [N-1:0]      vAddrM,
   input  logic [VEC_W-1:0]  vWriteDataM,
   input  logic              mem_ready,
   input  logic [BEAT_W-1:0] mem_rdata,
   output logic [N-1:0]      mem_addr,
   output logic [BEAT_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic [VEC_W-1:0]  vReadDataM,
   output logic              stallM,
   output logic              done,
   output logic              err
);

   localparam int unsigned BEATS   = beats_of(BEAT_W);
   localparam int unsigned BEAT_CW = cnt_w(BEATS);

   vseq_state_e        state_q, state_d;
   logic [BEAT_CW-1:0] beat_q, beat_d;
   logic [N-1:0]       base_q;
   logic               write_q;
   logic [VEC_W-1:0]   data_q;
   logic [VEC_W-1:0]   rdata_q;
   logic               start;
   logic               accept;
   logic               last;
   logic               expire;

   assign start  = (state_q == IDLE) && vMemOpM;
   assign accept = (state_q == ACCESS) && mem_ready && !expire;
   assign last   = (beat_q == BEAT_CW'(BEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      unique case (state_q)
         IDLE: begin
            if (vMemOpM) begin
               state_d = ACCESS;
               beat_d  = '0;
            end
         end
         ACCESS: begin
            if (expire) begin
               state_d = DONE;
            end else if (mem_ready) begin
               if (last) state_d = DONE;
               else      beat_d  = beat_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      if (state_q == ACCESS) begin
         mem_addr  = base_q + N'(beat_q);
         mem_wdata = data_q[beat_q*BEAT_W +: BEAT_W];
         mem_we    = write_q;
         mem_re    = !write_q;
      end
      // Gated by rst so every output reads 0 while reset is held.
      stallM = rst && ((state_q == ACCESS) || start);
      done   = (state_q == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         base_q  <= '0;
         write_q <= 1'b0;
         data_q  <= '0;
         rdata_q <= '0;
      end else begin
         if (start) begin
            base_q  <= vAddrM;
            write_q <= vWriteM;
            data_q  <= vWriteDataM;
         end
         if (accept && !write_q) begin
            rdata_q[beat_q*BEAT_W +: BEAT_W] <= mem_rdata;
         end
      end
   end

   assign vReadDataM = rdata_q;

`ifdef VSEQ_TIMEOUT_EN
   logic err_q;

   vseq_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .active (state_q == ACCESS),
      .ready  (mem_ready),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (start) begin
         err_q <= 1'b0;
      end else if (expire) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign expire         = 1'b0;
   assign err            = 1'b0;
`endif

endmodule
